// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
//   Shared definitions for the radix-4 Booth partial-product encoder.
//   - Default widths for multiplicand, multiplier, tag and the row count.
//   - booth_digit_t: the five radix-4 Booth digit values.
//   - booth_encode(): maps one overlapping multiplier bit triplet
//     {b[2i+1], b[2i], b[2i-1]} to its Booth digit.
// ---------------------------------------------------------------------------
package booth_pkg;

    localparam int DEF_A_W   = 12;
    localparam int DEF_B_W   = 11;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_NPP   = (DEF_B_W + 1) / 2;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_P1,
        BD_P2,
        BD_M1,
        BD_M2
    } booth_digit_t;

    // trip = {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_t booth_encode(input logic [2:0] trip);
        booth_digit_t dig;
        case (trip)
            3'b001, 3'b010: dig = BD_P1;
            3'b011:         dig = BD_P2;
            3'b100:         dig = BD_M2;
            3'b101, 3'b110: dig = BD_M1;
            default:        dig = BD_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_sel.sv
// ---------------------------------------------------------------------------
// booth_sel
//   Purely combinational row selector for one Booth digit.
//   Ports:
//     digit   - Booth digit for this row
//     a_ext   - multiplicand sign-extended by one bit (W = A_W+1)
//     row     - selected partial-product row
//     neg_bit - +1 correction completing the two's complement of a
//               negative row (row holds only the one's complement)
// ---------------------------------------------------------------------------
module booth_sel
    import booth_pkg::*;
#(
    parameter int W = DEF_A_W + 1
) (
    input  booth_digit_t   digit,
    input  logic [W-1:0]   a_ext,
    output logic [W-1:0]   row,
    output logic           neg_bit
);

    logic [W-1:0] a_x2;

    // Doubling inside W bits is exact: |2*A| never exceeds the signed range
    // of A_W+1 bits except for -2*(-2^(A_W-1)), which the neg bit restores.
    assign a_x2 = {a_ext[W-2:0], 1'b0};

    always_comb begin
        row     = '0;
        neg_bit = 1'b0;
        case (digit)
            BD_P1: row = a_ext;
            BD_P2: row = a_x2;
            BD_M1: begin
                row     = ~a_ext;
                neg_bit = 1'b1;
            end
            BD_M2: begin
                row     = ~a_x2;
                neg_bit = 1'b1;
            end
            default: begin
                row     = '0;
                neg_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_pp_encoder.sv
// ---------------------------------------------------------------------------
// booth_pp_encoder
//   Two-stage valid/ready pipeline producing radix-4 Booth partial products
//   for a signed A_W x B_W multiply. Rows feed a six-row Dadda tree; neg[i]
//   is the +1 of row i and belongs at column 2i.
//
//   S1: registers multiplicand, tag and the NPP encoded Booth digits.
//   S2: registers the selected rows, correction bits and tag.
//
//   Ports:
//     clk, rst_n         - clock, async active-low reset
//     flush              - synchronous clear of both stages
//     in_valid/in_ready  - input handshake; in_a, in_b, in_tag payload
//     out_valid/out_ready- output handshake; ops, neg, out_tag payload
//
//   Outputs are forced to zero whenever out_valid is low, so the
//   un-reset data registers never leak onto the ports.
// ---------------------------------------------------------------------------
module booth_pp_encoder
    import booth_pkg::*;
#(
    parameter  int A_W   = DEF_A_W,
    parameter  int B_W   = DEF_B_W,
    parameter  int TAG_W = DEF_TAG_W,
    localparam int NPP   = (B_W + 1) / 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [A_W-1:0]           in_a,
    input  logic [B_W-1:0]           in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NPP-1:0][A_W:0]    ops,
    output logic [NPP-1:0]           neg,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int W  = A_W + 1;
    localparam int BX = 2 * NPP;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   rdy_en_q, rdy_en_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s2_valid_q, s2_valid_d;

    logic [A_W-1:0]         s1_a_q, s1_a_d;
    logic [TAG_W-1:0]       s1_tag_q, s1_tag_d;
    booth_digit_t           s1_dig_q [NPP];
    booth_digit_t           s1_dig_d [NPP];

    logic [NPP-1:0][W-1:0]  s2_ops_q, s2_ops_d;
    logic [NPP-1:0]         s2_neg_q, s2_neg_d;
    logic [TAG_W-1:0]       s2_tag_q, s2_tag_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_adv, s2_adv, accept;

    assign s2_adv = !s2_valid_q || out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // rdy_en_q holds in_ready low through reset and releases it on the
    // first clock edge after rst_n deasserts.
    assign in_ready = rdy_en_q && !flush && s1_adv;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Booth encoding of the incoming multiplier
    // ------------------------------------------------------------------
    logic [BX-1:0]  b_ext;
    logic [BX:0]    b_pad;
    booth_digit_t   enc_dig [NPP];

    always_comb begin
        b_ext          = {BX{in_b[B_W-1]}};
        b_ext[B_W-1:0] = in_b;
        // Append the implicit b[-1] = 0 below bit 0.
        b_pad          = {b_ext, 1'b0};
        for (int i = 0; i < NPP; i++) begin
            enc_dig[i] = booth_encode(b_pad[2*i +: 3]);
        end
    end

    // ------------------------------------------------------------------
    // Row selection from S1 contents
    // ------------------------------------------------------------------
    logic [W-1:0]           a_ext;
    logic [NPP-1:0][W-1:0]  sel_row;
    logic [NPP-1:0]         sel_neg;

    assign a_ext = {s1_a_q[A_W-1], s1_a_q};

    for (genvar g = 0; g < NPP; g++) begin : g_sel
        booth_sel #(
            .W (W)
        ) u_sel (
            .digit   (s1_dig_q[g]),
            .a_ext   (a_ext),
            .row     (sel_row[g]),
            .neg_bit (sel_neg[g])
        );
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rdy_en_d = 1'b1;

        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_adv) s1_valid_d = accept;
            if (s2_adv) s2_valid_d = s1_valid_q;
        end

        s1_a_d   = s1_a_q;
        s1_tag_d = s1_tag_q;
        s1_dig_d = s1_dig_q;
        if (accept) begin
            s1_a_d   = in_a;
            s1_tag_d = in_tag;
            s1_dig_d = enc_dig;
        end

        s2_ops_d = s2_ops_q;
        s2_neg_d = s2_neg_q;
        s2_tag_d = s2_tag_q;
        if (s2_adv && s1_valid_q) begin
            s2_ops_d = sel_row;
            s2_neg_d = sel_neg;
            s2_tag_d = s1_tag_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers: only control bits are reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            rdy_en_q   <= rdy_en_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_a_q   <= s1_a_d;
        s1_tag_q <= s1_tag_d;
        s1_dig_q <= s1_dig_d;
        s2_ops_q <= s2_ops_d;
        s2_neg_q <= s2_neg_d;
        s2_tag_q <= s2_tag_d;
    end

    // ------------------------------------------------------------------
    // Outputs, gated by valid
    // ------------------------------------------------------------------
    assign out_valid = s2_valid_q;
    assign ops       = s2_valid_q ? s2_ops_q : '0;
    assign neg       = s2_valid_q ? s2_neg_q : '0;
    assign out_tag   = s2_valid_q ? s2_tag_q : '0;

endmodule

// File: tb/tb_booth_pp_encoder.sv
module tb_booth_pp_encoder;

    localparam int A_W   = 12;
    localparam int B_W   = 11;
    localparam int TAG_W = 4;
    localparam int NPP   = 6;
    localparam int W     = 13;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [A_W-1:0]         in_a;
    logic [B_W-1:0]         in_b;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [NPP-1:0][W-1:0]  ops;
    logic [NPP-1:0]         neg;
    logic [TAG_W-1:0]       out_tag;

    booth_pp_encoder #(
        .A_W   (A_W),
        .B_W   (B_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ops       (ops),
        .neg       (neg),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             a;
        int             b;
        logic [TAG_W-1:0] tag;
    } item_t;

    typedef struct {
        logic [A_W-1:0]        a;
        logic [B_W-1:0]        b;
        logic [NPP-1:0][W-1:0] e_ops;
        logic [NPP-1:0]        e_neg;
    } vec_t;

    int               n_tests = 0;
    int               n_fail  = 0;
    item_t            q[$];
    logic [TAG_W-1:0] out_log[$];
    logic             prev_rn = 1'b0;
    int               since_rst = 0;

    function automatic int sx(input int v, input int w);
        int t;
        t = v << (32 - w);
        return t >>> (32 - w);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Booth digit value d_i = b[2i-1] + b[2i] - 2*b[2i+1]; the row is
    // d_i*A for d_i >= 0, or the one's complement of |d_i|*A with a +1 bit.
    task automatic expect_item(input item_t it);
        int     av, bv, bm1, b0, b1, d, mag;
        logic [W-1:0] er;
        logic [NPP-1:0] en;
        longint sum;
        av  = sx(it.a, A_W);
        bv  = sx(it.b, B_W);
        sum = 0;
        en  = '0;
        for (int i = 0; i < NPP; i++) begin
            bm1 = (i == 0) ? 0 : ((bv >>> (2*i - 1)) & 1);
            b0  = (bv >>> (2*i)) & 1;
            b1  = (bv >>> (2*i + 1)) & 1;
            d   = bm1 + b0 - 2*b1;
            mag = ((d < 0) ? -d : d) * av;
            er  = (d < 0) ? W'(~mag) : W'(mag);
            en[i] = (d < 0);
            chk($sformatf("row%0d", i), longint'(ops[i]), longint'(er));
            sum += longint'(sx(int'(ops[i]), W) + int'(neg[i])) <<< (2*i);
        end
        chk("neg", longint'(neg), longint'(en));
        chk("tag", longint'(out_tag), longint'(it.tag));
        chk("weighted_sum", sum, longint'(av) * longint'(bv));
    endtask

    task automatic step(input logic v, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [TAG_W-1:0] t, input logic ordy, input logic fl,
                        input logic rn, output logic acc);
        item_t it;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        #1;
        acc = 1'b0;
        if (!rn) begin
            chk("rst_in_ready", longint'(in_ready), 0);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_outs_zero", longint'(ops == '0 && neg == '0 && out_tag == '0), 1);
            q.delete();
            since_rst = 0;
        end else begin
            if (!prev_rn) chk("ready_low_at_deassert", longint'(in_ready), 0);
            if (since_rst == 1 && !fl) chk("ready_first_edge", longint'(in_ready), 1);
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else expect_item(q[0]);
            end
            if (!ordy && q.size() == 2) chk("full_in_ready", longint'(in_ready), 0);
            if (out_valid && ordy && q.size() > 0) begin
                void'(q.pop_front());
                out_log.push_back(out_tag);
            end
            if (fl) begin
                chk("flush_in_ready", longint'(in_ready), 0);
                q.delete();
            end else if (v && in_ready) begin
                it.a   = int'(a);
                it.b   = int'(b);
                it.tag = t;
                q.push_back(it);
                acc = 1'b1;
            end
            since_rst++;
        end
        prev_rn = rn;
        @(posedge clk);
    endtask

    vec_t vt[7];

    initial begin
        logic acc;
        int   nxt, cyc;
        logic v, ordy, fl, rn;
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;

        for (int k = 0; k < 7; k++) begin
            vt[k].e_ops = '0;
            vt[k].e_neg = '0;
        end
        vt[0].a = 12'h001; vt[0].b = 11'h001; vt[0].e_ops[0] = 13'h0001;
        vt[1].a = 12'h001; vt[1].b = 11'h7FF; vt[1].e_ops[0] = 13'h1FFE; vt[1].e_neg = 6'b000001;
        vt[2].a = 12'h800; vt[2].b = 11'h002; vt[2].e_ops[0] = 13'h0FFF; vt[2].e_ops[1] = 13'h1800;
        vt[2].e_neg = 6'b000001;
        vt[3].a = 12'h800; vt[3].b = 11'h400; vt[3].e_ops[5] = 13'h07FF; vt[3].e_neg = 6'b100000;
        vt[4].a = 12'h7FF; vt[4].b = 11'h3FF; vt[4].e_ops[0] = 13'h1800; vt[4].e_ops[5] = 13'h07FF;
        vt[4].e_neg = 6'b000001;
        vt[5].a = 12'h003; vt[5].b = 11'h003; vt[5].e_ops[0] = 13'h1FFC; vt[5].e_ops[1] = 13'h0003;
        vt[5].e_neg = 6'b000001;
        vt[6].a = 12'h000; vt[6].b = 11'h000;

        repeat (3) step(0, '0, '0, '0, 1, 0, 0, acc);
        repeat (2) step(0, '0, '0, '0, 1, 0, 1, acc);

        // Directed table: latency and exact rows
        for (int k = 0; k < 7; k++) begin
            step(1, vt[k].a, vt[k].b, TAG_W'(k), 0, 0, 1, acc);
            chk("vec_accept", longint'(acc), 1);
            #1;
            chk("vec_lat1_valid", longint'(out_valid), 0);
            step(0, '0, '0, '0, 0, 0, 1, acc);
            #1;
            chk("vec_lat2_valid", longint'(out_valid), 1);
            for (int i = 0; i < NPP; i++)
                chk($sformatf("vec%0d_row%0d", k, i), longint'(ops[i]), longint'(vt[k].e_ops[i]));
            chk($sformatf("vec%0d_neg", k), longint'(neg), longint'(vt[k].e_neg));
            step(0, '0, '0, '0, 1, 0, 1, acc);
        end

        // Back-pressure: tags 0..7 with a 5-cycle stall mid-stream
        out_log.delete();
        nxt = 0;
        cyc = 0;
        while (out_log.size() < 8 && cyc < 60) begin
            ordy = !(cyc >= 4 && cyc < 9);
            step(nxt < 8, A_W'($urandom), B_W'($urandom), TAG_W'(nxt), ordy, 0, 1, acc);
            if (acc) nxt++;
            cyc++;
        end
        chk("bp_count", out_log.size(), 8);
        for (int k = 0; k < out_log.size() && k < 8; k++)
            chk("bp_order", longint'(out_log[k]), k);

        // Random traffic with occasional flush and reset pulses
        for (int n = 0; n < 20000; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 99) == 0);
            rn   = ($urandom_range(0, 299) != 0);
            ra   = A_W'($urandom);
            rb   = B_W'($urandom);
            if (n % 50 == 0) begin
                ra = 12'h800;
                rb = 11'h400;
            end
            step(v, ra, rb, TAG_W'($urandom), ordy, fl, rn, acc);
        end

        for (int k = 0; k < 4; k++) step(0, '0, '0, '0, 1, 0, 1, acc);
        chk("drain_empty", q.size(), 0);
        #1;
        chk("drain_out_valid", longint'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
